// File: rtl/ibex_cust_sad_seq.sv
// Sequential sum-of-absolute-lane-differences unit for the EX stage.
// It computes each lane difference locally and does all accumulation on the shared ALU adder.
module ibex_cust_sad_seq #(
  parameter int unsigned LaneW = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        signed_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  output logic [32:0] alu_operand_a_o,
  output logic [32:0] alu_operand_b_o,
  output logic        alu_en_o,
  input  logic [33:0] alu_adder_ext_i,
  output logic [31:0] result_o,
  output logic        valid_o,
  output logic        busy_o
);

  localparam int unsigned N    = 32 / LaneW;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;

  state_e            state;
  logic [IdxW-1:0]   idx;
  logic [31:0]       acc;
  logic [31:0]       a_q;
  logic [31:0]       b_q;
  logic              signed_q;

  logic [LaneW-1:0]  lane_a;
  logic [LaneW-1:0]  lane_b;
  logic [LaneW:0]    ext_a;
  logic [LaneW:0]    ext_b;
  logic [LaneW:0]    delta;
  logic [LaneW:0]    diff;
  logic [31:0]       sum;
  logic              last;
  logic              unused_ext;

  // The extra bit makes the subtraction exact for both signed and unsigned lanes.
  always_comb begin
    lane_a = a_q[32'(idx) * LaneW +: LaneW];
    lane_b = b_q[32'(idx) * LaneW +: LaneW];
    ext_a  = {signed_q & lane_a[LaneW-1], lane_a};
    ext_b  = {signed_q & lane_b[LaneW-1], lane_b};
    delta  = ext_a - ext_b;
    diff   = delta[LaneW] ? -delta : delta;
  end

  // Operands are forced to zero whenever the adder is not ours.
  assign alu_operand_a_o = alu_en_o ? {acc, 1'b0} : '0;
  assign alu_operand_b_o = alu_en_o ? 33'({diff, 1'b0}) : '0;
  assign sum             = alu_adder_ext_i[32:1];
  assign last            = (idx == IdxW'(N - 1));
  assign unused_ext      = alu_adder_ext_i[33] ^ alu_adder_ext_i[0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      idx      <= '0;
      acc      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      result_o <= '0;
      valid_o  <= 1'b0;
      busy_o   <= 1'b0;
      alu_en_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en_i) begin
            a_q      <= operand_a_i;
            b_q      <= operand_b_i;
            signed_q <= signed_i;
            acc      <= '0;
            idx      <= '0;
            result_o <= '0;
            state    <= ACC;
            alu_en_o <= 1'b1;
            busy_o   <= 1'b1;
          end
        end
        ACC: begin
          if (!en_i) begin
            state    <= IDLE;
            alu_en_o <= 1'b0;
            busy_o   <= 1'b0;
          end else begin
            acc <= sum;
            idx <= idx + 1'b1;
            if (last) begin
              state    <= DONE;
              result_o <= sum;
              valid_o  <= 1'b1;
              alu_en_o <= 1'b0;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
